// File: rtl/isi_seq_pkg.sv
// Shared types and default widths for the ISI timestamp sequencer.
package isi_seq_pkg;

  // Default widths: period counter, tstamp length, saturating tstamp counter.
  localparam int DEF_W_PER = 16;
  localparam int DEF_W_TS  = 8;
  localparam int DEF_W_CNT = 16;

  // Sequencer states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

endpackage

// File: rtl/clk_low_edge.sv
// Edge detector for clk_low, which is sampled as data in the clk_main domain.
module clk_low_edge (
  input  logic clk_main,
  input  logic clr,
  input  logic clk_low,
  output logic rise,
  output logic fall
);

  logic clk_low_de;

  // Delay clk_low by one clk_main; reset to 1 so a high clk_low right after clr is never seen as a rise.
  // NOTE: sequential state is written with <= so every register samples the pre-edge values.
  always_ff @(posedge clk_main) begin
    if (clr) begin
      clk_low_de <= 1'b1;
    end else begin
      clk_low_de <= clk_low;
    end
  end

  assign rise = clk_low & ~clk_low_de;
  assign fall = ~clk_low & clk_low_de;

endmodule

// File: rtl/isi_tstamp_sequencer.sv
// ISI timestamp sequencer: drives the gain-clock inhibit window (exp_w1) and the
// timestamp pulse train (tstamp/tstamp_de) while an ISI record is active.
// All state changes that the gain-clock generator sees happen on the clk_main
// edge after a clk_low fall, so they are stable at every clk_low rise.
module isi_tstamp_sequencer
  import isi_seq_pkg::*;
#(
  parameter int W_PER = DEF_W_PER,
  parameter int W_TS  = DEF_W_TS,
  parameter int W_CNT = DEF_W_CNT
) (
  input  logic             clk_main,
  input  logic             clr,
  input  logic             clk_low,
  input  logic             en,
  input  logic             s_isi_rec,
  input  logic [W_PER-1:0] cfg_period,
  input  logic [W_TS-1:0]  cfg_ts_len,
  output logic             exp_w1,
  output logic             exp_w1_de1,
  output logic             tstamp,
  output logic             tstamp_de,
  output logic [W_CNT-1:0] ts_cnt,
  output logic             busy,
  output logic             cfg_err
);

  seq_state_t       state;
  logic [W_PER-1:0] per_cnt;   // falls since the last tstamp rise, 0..P-1
  logic [W_PER-1:0] p_lat;     // latched cfg_period
  logic [W_TS-1:0]  l_lat;     // latched cfg_ts_len
  logic             rec_bad;   // current record has a bad config: no tstamps

  logic             fall;
  logic             rise_unused;  // the sequencer acts on falls only

  logic             rec_on;
  logic             cfg_bad;
  logic [W_PER-1:0] l_ext;
  logic [W_PER-1:0] p_last;
  logic [W_PER-1:0] ts_end;

  clk_low_edge u_edge (
    .clk_main (clk_main),
    .clr      (clr),
    .clk_low  (clk_low),
    .rise     (rise_unused),
    .fall     (fall)
  );

  // Record qualifier, config check and the per_cnt value at which tstamp drops.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    rec_on  = en & s_isi_rec;
    cfg_bad = (cfg_period < W_PER'(2)) || (cfg_ts_len == '0);
    l_ext   = W_PER'(l_lat);
    p_last  = p_lat - W_PER'(1);
    // Clamping to P-1 leaves at least one low period before the next rise.
    ts_end  = (l_ext < p_last) ? l_ext : p_last;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge clk_main) begin
    if (clr) begin
      state      <= IDLE;
      per_cnt    <= '0;
      p_lat      <= '0;
      l_lat      <= '0;
      rec_bad    <= 1'b0;
      exp_w1     <= 1'b1;
      exp_w1_de1 <= 1'b1;
      tstamp     <= 1'b0;
      tstamp_de  <= 1'b0;
      ts_cnt     <= '0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      exp_w1_de1 <= exp_w1;

      // tstamp_de lags tstamp by exactly one clk_low period.
      if (fall) begin
        tstamp_de <= tstamp;
      end

      case (state)
        IDLE: begin
          if (rec_on) begin
            state <= ARM;
            busy  <= 1'b1;
          end
        end

        ARM: begin
          // Config is only captured here, aligned to a clk_low fall.
          if (fall) begin
            p_lat   <= cfg_period;
            l_lat   <= cfg_ts_len;
            rec_bad <= cfg_bad;
            if (cfg_bad) begin
              cfg_err <= 1'b1;
            end
            ts_cnt  <= '0;
            per_cnt <= '0;
            exp_w1  <= 1'b0;
            state   <= RUN;
          end
        end

        RUN: begin
          // A record drop takes priority over a coincident fall: no new tstamp.
          if (!rec_on) begin
            state <= DRAIN;
          end else if (fall) begin
            per_cnt <= (per_cnt == p_last) ? '0 : per_cnt + W_PER'(1);
            if (per_cnt == ts_end) begin
              tstamp <= 1'b0;
            end
            if ((per_cnt == '0) && !rec_bad) begin
              tstamp <= 1'b1;
              if (ts_cnt != '1) begin
                ts_cnt <= ts_cnt + W_CNT'(1);
              end
            end
          end
        end

        DRAIN: begin
          // Truncate any active tstamp, then close the window on the fall where tstamp_de clears.
          if (fall) begin
            tstamp <= 1'b0;
            if (!tstamp) begin
              exp_w1 <= 1'b1;
              busy   <= 1'b0;
              state  <= IDLE;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_isi_tstamp_sequencer.sv
// Directed bench for isi_tstamp_sequencer. clk_low = clk_main/8, so one low
// period is 8 clk_main cycles. A second instance with W_CNT=3 checks saturation.
module tb_isi_tstamp_sequencer;

  localparam int W_PER = 16;
  localparam int W_TS  = 8;
  localparam int W_CNT = 16;
  localparam int W_SAT = 3;

  logic             clk_main = 1'b0;
  logic             clr;
  logic             clk_low;
  logic             en;
  logic             s_isi_rec;
  logic [W_PER-1:0] cfg_period;
  logic [W_TS-1:0]  cfg_ts_len;

  logic             exp_w1, exp_w1_de1, tstamp, tstamp_de, busy, cfg_err;
  logic [W_CNT-1:0] ts_cnt;

  logic             s_exp_w1, s_exp_w1_de1, s_tstamp, s_tstamp_de, s_busy, s_cfg_err;
  logic [W_SAT-1:0] s_ts_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int m_ts;     // model tstamp after the last fall
  int m_cnt;    // model tstamp count in the current record
  bit m_err;    // model sticky cfg_err

  isi_tstamp_sequencer #(.W_PER(W_PER), .W_TS(W_TS), .W_CNT(W_CNT)) dut (
    .clk_main   (clk_main),
    .clr        (clr),
    .clk_low    (clk_low),
    .en         (en),
    .s_isi_rec  (s_isi_rec),
    .cfg_period (cfg_period),
    .cfg_ts_len (cfg_ts_len),
    .exp_w1     (exp_w1),
    .exp_w1_de1 (exp_w1_de1),
    .tstamp     (tstamp),
    .tstamp_de  (tstamp_de),
    .ts_cnt     (ts_cnt),
    .busy       (busy),
    .cfg_err    (cfg_err)
  );

  isi_tstamp_sequencer #(.W_PER(W_PER), .W_TS(W_TS), .W_CNT(W_SAT)) dut_sat (
    .clk_main   (clk_main),
    .clr        (clr),
    .clk_low    (clk_low),
    .en         (en),
    .s_isi_rec  (s_isi_rec),
    .cfg_period (cfg_period),
    .cfg_ts_len (cfg_ts_len),
    .exp_w1     (s_exp_w1),
    .exp_w1_de1 (s_exp_w1_de1),
    .tstamp     (s_tstamp),
    .tstamp_de  (s_tstamp_de),
    .ts_cnt     (s_ts_cnt),
    .busy       (s_busy),
    .cfg_err    (s_cfg_err)
  );

  // clk_main: posedges at 5, 15, 25, ...
  initial forever #5 clk_main = ~clk_main;

  // clk_low toggles every 4 clk_main cycles, 3 ns before a clk_main posedge.
  initial begin
    clk_low = 1'b0;
    #2;
    forever #40 clk_low = ~clk_low;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit cfg_ok(int p, int l);
    return (p >= 2) && (l != 0);
  endfunction

  // Model tstamp after the k-th fall of a record (k=1 is the first fall in RUN).
  function automatic bit ts_model(int k, int p, int l);
    int e;
    if (!cfg_ok(p, l)) return 1'b0;
    e = (l < p - 1) ? l : p - 1;
    return ((k - 1) % p) < e;
  endfunction

  function automatic int sat(int v);
    return (v > 7) ? 7 : v;
  endfunction

  // Wait for a clk_low fall and sample just after the clk_main edge that acts on it.
  task automatic next_fall();
    @(negedge clk_low);
    @(posedge clk_main);
    #1;
  endtask

  task automatic check_reset(input string name);
    check({name, ".exp_w1"},     exp_w1,     1);
    check({name, ".exp_w1_de1"}, exp_w1_de1, 1);
    check({name, ".tstamp"},     tstamp,     0);
    check({name, ".tstamp_de"},  tstamp_de,  0);
    check({name, ".ts_cnt"},     ts_cnt,     0);
    check({name, ".busy"},       busy,       0);
    check({name, ".cfg_err"},    cfg_err,    0);
    check({name, ".s_exp_w1"},   s_exp_w1,   1);
    check({name, ".s_de1"},      s_exp_w1_de1, 1);
    check({name, ".s_tstamp"},   s_tstamp,   0);
    check({name, ".s_ts_de"},    s_tstamp_de, 0);
    check({name, ".s_ts_cnt"},   s_ts_cnt,   0);
    check({name, ".s_busy"},     s_busy,     0);
    check({name, ".s_cfg_err"},  s_cfg_err,  0);
  endtask

  // Raise the record from IDLE and check the ARM->RUN fall (F0).
  task automatic start_rec(input string name, input int p, input int l);
    cfg_period = p[W_PER-1:0];
    cfg_ts_len = l[W_TS-1:0];
    en         = 1'b1;
    s_isi_rec  = 1'b1;
    next_fall();
    if (!cfg_ok(p, l)) m_err = 1'b1;
    m_ts  = 0;
    m_cnt = 0;
    check({name, ".f0.exp_w1"},     exp_w1,     0);
    check({name, ".f0.exp_w1_de1"}, exp_w1_de1, 1);
    check({name, ".f0.busy"},       busy,       1);
    check({name, ".f0.tstamp"},     tstamp,     0);
    check({name, ".f0.ts_cnt"},     ts_cnt,     0);
    check({name, ".f0.cfg_err"},    cfg_err,    32'(m_err));
  endtask

  task automatic run_falls(input string name, input int n, input int p, input int l);
    for (int k = 1; k <= n; k++) begin
      bit e;
      next_fall();
      e = ts_model(k, p, l);
      if (cfg_ok(p, l) && ((k - 1) % p == 0)) m_cnt++;
      check({name, ".tstamp"},    tstamp,    32'(e));
      check({name, ".tstamp_de"}, tstamp_de, 32'(m_ts));
      check({name, ".ts_cnt"},    ts_cnt,    32'(m_cnt));
      check({name, ".s_ts_cnt"},  s_ts_cnt,  32'(sat(m_cnt)));
      check({name, ".s_tstamp"},  s_tstamp,  32'(e));
      check({name, ".exp_w1"},    exp_w1,    0);
      m_ts = e;
    end
  endtask

  // Drop the record and expect the window to close on the n-th fall.
  task automatic drain(input string name, input int n);
    s_isi_rec = 1'b0;
    for (int i = 1; i <= n; i++) begin
      next_fall();
      check({name, ".dr.tstamp"},    tstamp,    0);
      check({name, ".dr.tstamp_de"}, tstamp_de, 32'(m_ts));
      check({name, ".dr.exp_w1"},    exp_w1,    32'(i == n));
      check({name, ".dr.s_exp_w1"},  s_exp_w1,  32'(i == n));
      check({name, ".dr.busy"},      busy,      32'(i != n));
      m_ts = 0;
    end
    check({name, ".dr.ts_cnt"},     ts_cnt,     32'(m_cnt));
    check({name, ".dr.s_ts_cnt"},   s_ts_cnt,   32'(sat(m_cnt)));
    check({name, ".dr.exp_w1_de1"}, exp_w1_de1, 0);
    @(posedge clk_main);
    #1;
    check({name, ".dr.exp_w1_de1+1"}, exp_w1_de1, 1);
  endtask

  initial begin
    clr        = 1'b1;
    en         = 1'b0;
    s_isi_rec  = 1'b0;
    cfg_period = '0;
    cfg_ts_len = '0;
    m_err      = 1'b0;
    m_ts       = 0;
    m_cnt      = 0;
    repeat (3) @(posedge clk_main);
    #1;
    check_reset("reset");
    clr = 1'b0;
    next_fall();

    // T1: period 4, length 1, record held 20 low periods -> 5 tstamps.
    start_rec("t1", 4, 1);
    run_falls("t1", 20, 4, 1);
    drain("t1", 1);
    check("t1.ts_cnt_final", ts_cnt, 5);

    // T2: length clamped to P-1: 2 periods high, 1 low.
    start_rec("t2", 3, 5);
    run_falls("t2", 6, 3, 5);
    check("t2.cfg_err", cfg_err, 0);
    drain("t2", 1);

    // T3: drop while tstamp is high; tstamp truncated at next fall, window closes one fall later.
    start_rec("t3", 4, 2);
    run_falls("t3", 1, 4, 2);
    check("t3.tstamp_high", tstamp, 1);
    drain("t3", 2);

    // T4: drop coincident with the fall that would start the next tstamp.
    start_rec("t4", 4, 1);
    run_falls("t4", 4, 4, 1);
    @(negedge clk_low);
    s_isi_rec = 1'b0;
    @(posedge clk_main);
    #1;
    check("t4.tstamp",    tstamp,    0);
    check("t4.tstamp_de", tstamp_de, 0);
    check("t4.ts_cnt",    ts_cnt,    1);
    check("t4.busy",      busy,      1);
    check("t4.exp_w1",    exp_w1,    0);
    next_fall();
    check("t4.end.exp_w1", exp_w1, 1);
    check("t4.end.busy",   busy,   0);
    check("t4.end.tstamp", tstamp, 0);
    check("t4.end.ts_cnt", ts_cnt, 1);

    // T7: period 2 for 17 falls -> 9 tstamps; 3-bit counter holds at 7.
    start_rec("t7", 2, 1);
    run_falls("t7", 17, 2, 1);
    check("t7.ts_cnt",   ts_cnt,   9);
    check("t7.s_ts_cnt", s_ts_cnt, 7);
    drain("t7", 2);

    // T5: clr pulse mid-record with tstamp high, applied while clk_low is high.
    start_rec("t5", 4, 2);
    run_falls("t5", 1, 4, 2);
    check("t5.pre.tstamp", tstamp, 1);
    @(posedge clk_low);
    clr = 1'b1;
    @(posedge clk_main);
    #1;
    clr       = 1'b0;
    en        = 1'b0;
    s_isi_rec = 1'b0;
    m_err     = 1'b0;
    m_ts      = 0;
    m_cnt     = 0;
    check_reset("t5");
    check("t5.clk_low", clk_low, 1);
    check("t5.no_rise", dut.u_edge.rise, 0);

    // T6: period 1 -> cfg_err, window open, no tstamps; cfg_err stays set.
    next_fall();
    start_rec("t6", 1, 3);
    run_falls("t6", 4, 1, 3);
    drain("t6", 1);
    check("t6.cfg_err",   cfg_err,   1);
    check("t6.s_cfg_err", s_cfg_err, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
